// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions used by the fetch stage and the decode controller.
package kgp_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'b0;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/kgp_fetch_queue.sv
// Prefetch FIFO: push/pop/flush, occupancy count, head read from registered storage.
module kgp_fetch_queue
    import kgp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

endmodule

// File: rtl/kgp_fetch_unit.sv
// KGP-RISC instruction fetch: PC, imem req/ack handshake, redirect/drop, prefetch queue.
module kgp_fetch_unit
    import kgp_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               pcsrc,
    input  logic [31:0]        target,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid
);
    localparam int          CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic          pending;
    logic          drop;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    logic          head_valid;
    logic          done;
    logic          push;
    logic          pop;
    logic          issue;

    assign done  = pending && imem_ack;
    assign push  = done && !drop && !pcsrc;
    assign pop   = head_valid && !stall && !pcsrc;
    // Only one request in flight, so the slot it will fill is reserved by the
    // !pending term; a redirect edge never issues because fetch_pc is changing.
    assign issue = !pending && !pcsrc && (count < FULL);

    // Handshake, PC and drop tracking. req_addr is separate from fetch_pc so the
    // request address stays stable even if a redirect lands while it is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC & ~32'h3;
            req_addr <= RESET_PC & ~32'h3;
            pending  <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (issue) begin
                pending  <= 1'b1;
                req_addr <= fetch_pc;
            end else if (done) begin
                pending  <= 1'b0;
            end
            if (pcsrc)     fetch_pc <= target & ~32'h3;
            else if (push) fetch_pc <= fetch_pc + PC_STEP;
            if (done)                  drop <= 1'b0;
            else if (pcsrc && pending) drop <= 1'b1;
        end
    end

    kgp_fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ('{pc: req_addr, word: imem_rdata}),
        .pop        (pop),
        .flush      (pcsrc),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign imem_req    = pending;
    assign imem_addr   = req_addr;
    assign instr_valid = head_valid;
    assign instr       = head_valid ? head.word : NOP_INSTR;
    assign instr_pc    = head_valid ? head.pc   : 32'b0;

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Self-checking bench for kgp_fetch_unit: memory model, in-order scoreboard, scenario table.
module tb_kgp_fetch_unit;
    import kgp_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'b0;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] target = 32'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    kgp_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk), .reset (reset),
        .imem_req (imem_req), .imem_addr (imem_addr), .imem_ack (imem_ack), .imem_rdata (imem_rdata),
        .stall (stall), .pcsrc (pcsrc), .target (target),
        .instr (instr), .instr_pc (instr_pc), .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory word at address a is ~a, so it is never the NOP pattern.
    function automatic fetch_entry_t ent(input logic [31:0] a);
        return '{pc: a, word: ~a};
    endfunction

    // Instruction memory: acks mem_lat cycles after the request appears.
    int mem_lat = 0;
    bit mem_en = 1'b1;
    int wait_cnt = 0;
    always @(negedge clk) begin
        if (reset || !imem_req || !mem_en) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = ~imem_addr;
            wait_cnt   = 0;
        end else begin
            imem_ack = 1'b0;
            wait_cnt++;
        end
    end

    // Handshake log, sampled at the active edge before the DUT updates.
    int          cyc = 0;
    logic [31:0] ack_addr[$];
    int          ack_cyc[$];
    logic        hs_req = 1'b0;
    logic        hs_ack = 1'b0;
    logic [31:0] hs_addr = 32'b0;
    always @(posedge clk) begin
        if (!reset && imem_req && imem_ack) begin
            ack_addr.push_back(imem_addr);
            ack_cyc.push_back(cyc);
        end
        hs_req  = imem_req && !reset;
        hs_ack  = imem_ack;
        hs_addr = imem_addr;
        cyc++;
    end

    // Consumer side: every instruction decode accepts is popped from the scoreboard.
    fetch_entry_t sb[$];
    bit mon_en = 1'b0;
    int first_val = -1;
    always @(negedge clk) begin
        fetch_entry_t e;
        if (!reset && mon_en) begin
            if (hs_req && !hs_ack) begin
                check("req_held", {31'b0, imem_req}, 32'd1);
                check("addr_held", imem_addr, hs_addr);
            end
            if (instr_valid && first_val < 0) first_val = cyc;
            if (!instr_valid) begin
                check("nop_when_invalid", instr | instr_pc, 32'b0);
            end else if (!stall && !pcsrc) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL extra_instr: got pc %h, none expected", instr_pc);
                end else begin
                    e = sb.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr", instr, e.word);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; stall = 1'b0; pcsrc = 1'b0; target = 32'b0; mem_en = 1'b1;
        mon_en = 1'b0; first_val = -1;
        sb.delete(); ack_addr.delete(); ack_cyc.delete();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic run_until_empty(input int max, input int stall_pct, input string name);
        for (int i = 0; i < max && sb.size() != 0; i++) begin
            tick();
            stall = ($urandom_range(0, 99) < stall_pct);
        end
        stall = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL %s_timeout: %0d entries still expected after %0d cycles", name, sb.size(), max);
        end
        mon_en = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, RESET_PC);
        check({tag, "_instr"}, instr, NOP_INSTR);
        check({tag, "_instr_pc"}, instr_pc, 32'b0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    endtask

    typedef struct {
        int lat;         // memory wait cycles
        int stall_pct;   // chance of stall per cycle
        int n;           // words to consume
        int exp_lat;     // cycles from first ack to first instr_valid
        int exp_period;  // cycles between acks with no backpressure, -1 = not checked
    } vec_t;

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        bit   found;
        vecs[0] = '{lat: 1, stall_pct: 0,  n: 10, exp_lat: 1, exp_period: 3};
        vecs[1] = '{lat: 0, stall_pct: 0,  n: 10, exp_lat: 1, exp_period: 2};
        vecs[2] = '{lat: 2, stall_pct: 40, n: 12, exp_lat: 1, exp_period: -1};
        vecs[3] = '{lat: 0, stall_pct: 60, n: 16, exp_lat: 1, exp_period: -1};

        // Reset state and first request timing.
        reset = 1'b1;
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("no_req_before_edge", {31'b0, imem_req}, 32'd0);
        tick();
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RESET_PC);

        // Streaming scenarios.
        foreach (vecs[v]) begin
            mem_lat = vecs[v].lat;
            apply_reset();
            for (int k = 0; k < vecs[v].n; k++) sb.push_back(ent(32'(4 * k)));
            mon_en = 1'b1;
            run_until_empty(vecs[v].n * (vecs[v].lat + 2) * 8 + 50, vecs[v].stall_pct, "stream");
            n_checks++;
            if (ack_cyc.size() < vecs[v].n) begin
                n_fails++;
                $display("FAIL stream_acks: got %0d acks, expected at least %0d", ack_cyc.size(), vecs[v].n);
            end else begin
                check("first_valid_latency", 32'(first_val - ack_cyc[0]), 32'(vecs[v].exp_lat));
                if (vecs[v].exp_period >= 0)
                    check("throughput", 32'(ack_cyc[vecs[v].n - 1] - ack_cyc[0]),
                          32'((vecs[v].n - 1) * vecs[v].exp_period));
            end
        end

        // Stall with a full queue: exactly DEPTH words buffered, no request, head held.
        mem_lat = 0;
        apply_reset();
        stall = 1'b1;
        for (int k = 0; k < 8; k++) sb.push_back(ent(32'(4 * k)));
        mon_en = 1'b1;
        repeat (10) tick();
        check("full_acks", 32'(ack_addr.size()), 32'(DEPTH));
        for (int i = 0; i < 4; i++) begin
            check("full_no_req", {31'b0, imem_req}, 32'd0);
            check("full_hold_pc", instr_pc, 32'h0);
            check("full_hold_instr", instr, ~32'h0);
            tick();
        end
        stall = 1'b0;
        run_until_empty(100, 0, "drain");

        // Redirect while the 0x10 request is pending.
        apply_reset();
        for (int k = 0; k < 4; k++) sb.push_back(ent(32'(4 * k)));
        mon_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
        end
        mem_en = 1'b0;
        check("pending_0x10", imem_addr, 32'h10);
        check("pre_redirect_drained", 32'(sb.size()), 32'd0);
        tick();
        pcsrc = 1'b1; target = 32'h0000_0103;
        tick();
        pcsrc = 1'b0;
        check("redir_valid", {31'b0, instr_valid}, 32'd0);
        check("redir_addr_held", imem_addr, 32'h10);
        ack_addr.delete();
        for (int k = 0; k < 3; k++) sb.push_back(ent(32'h100 + 32'(4 * k)));
        mem_en = 1'b1;
        run_until_empty(60, 0, "redirect");
        check("dropped_ack_addr", (ack_addr.size() > 0) ? ack_addr[0] : 32'hDEAD_BEEF, 32'h10);
        check("redirect_addr", (ack_addr.size() > 1) ? ack_addr[1] : 32'hDEAD_BEEF, 32'h100);

        // Redirect on the same edge as an ack: word discarded, queue flushed.
        apply_reset();
        stall = 1'b1;
        mon_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        pcsrc = 1'b1; target = 32'h0000_0200;
        ack_addr.delete();
        tick();
        pcsrc = 1'b0; stall = 1'b0;
        check("same_edge_flush", {31'b0, instr_valid}, 32'd0);
        check("same_edge_no_req", {31'b0, imem_req}, 32'd0);
        sb.push_back(ent(32'h200));
        sb.push_back(ent(32'h204));
        run_until_empty(60, 0, "same_edge");
        check("same_edge_acked", (ack_addr.size() > 0) ? ack_addr[0] : 32'hDEAD_BEEF, 32'h8);
        check("same_edge_target", (ack_addr.size() > 1) ? ack_addr[1] : 32'hDEAD_BEEF, 32'h200);

        // fetch_pc wrap through 0xFFFF_FFFC; low target bits ignored.
        apply_reset();
        pcsrc = 1'b1; target = 32'hFFFF_FFFA;
        sb.push_back(ent(32'hFFFF_FFF8));
        sb.push_back(ent(32'hFFFF_FFFC));
        sb.push_back(ent(32'h0));
        sb.push_back(ent(32'h4));
        mon_en = 1'b1;
        tick();
        pcsrc = 1'b0;
        run_until_empty(60, 0, "wrap");
        check("wrap_addr", (ack_addr.size() > 2) ? ack_addr[2] : 32'hDEAD_BEEF, 32'h0);

        // Asynchronous reset between edges while a request is outstanding.
        mem_lat = 3;
        apply_reset();
        for (int i = 0; i < 5 && !imem_req; i++) tick();
        check("mid_req_up", {31'b0, imem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        mem_lat = 0;
        apply_reset();
        sb.push_back(ent(32'h0));
        sb.push_back(ent(32'h4));
        mon_en = 1'b1;
        run_until_empty(60, 0, "restart");
        check("restart_addr", (ack_addr.size() > 0) ? ack_addr[0] : 32'hDEAD_BEEF, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
